// File: rtl/dbg_uart_tx_fifo.sv
// Debug UART transmitter fed by a small byte FIFO.
// 8N1 framing, LSB first; the serial line idles high and is always driven from a flop.
module dbg_uart_tx_fifo #(
    parameter int CLK_HZ   = 14_000_000,
    parameter int BIT_RATE = 1_000_000,
    parameter int DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       full,
    output logic [4:0] level,
    output logic       busy,
    output logic       overflow,
    output logic       uart_txd
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int         PTR_W        = $clog2(DEPTH);
    localparam logic [7:0] DIV_LAST     = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LVL_FULL     = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         shifter;
    logic [7:0]         div_cnt;
    logic [7:0]         div_nxt;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_nxt;
    logic               txd_nxt;
    logic               push;
    logic               drop;
    logic               pop;
    logic               load;
    logic               shift;
    logic               bit_end;

    // Full is judged on the pre-edge level, so a write racing a pop while full is still dropped.
    assign full    = (level == LVL_FULL);
    assign push    = wr_en && !full;
    assign drop    = wr_en && full;
    assign busy    = (state != IDLE) || (level != 5'd0);
    assign bit_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt + 8'd1;
        bit_nxt   = bit_cnt;
        txd_nxt   = uart_txd;
        pop       = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                div_nxt = '0;
                if (level != 5'd0) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    txd_nxt   = 1'b0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_nxt   = '0;
                    txd_nxt   = shifter[0];
                    shift     = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        txd_nxt   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        txd_nxt = shifter[0];
                        shift   = 1'b1;
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when data is waiting: no idle gap.
                if (bit_end) begin
                    div_nxt = '0;
                    if (level != 5'd0) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        txd_nxt   = 1'b0;
                        bit_nxt   = '0;
                        state_nxt = START;
                    end else begin
                        txd_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            uart_txd <= txd_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            level    <= level + 5'(push) - 5'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage and shifter carry data only; control state decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
        if (load) begin
            shifter <= mem[rd_ptr];
        end else if (shift) begin
            shifter <= {1'b0, shifter[7:1]};
        end
    end

endmodule

// File: tb/tb_dbg_uart_tx_fifo.sv
// Randomized bench for dbg_uart_tx_fifo against a queue-and-frame-timer reference model.
module tb_dbg_uart_tx_fifo;

    localparam int CLK_HZ   = 14_000_000;
    localparam int BIT_RATE = 1_000_000;
    localparam int DEPTH    = 8;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int FRAME    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full;
    logic [4:0] level;
    logic       busy;
    logic       overflow;
    logic       uart_txd;

    int errs   = 0;
    int checks = 0;

    // Reference model: queued bytes, cycles since current start edge (-1 when no frame).
    byte unsigned m_q[$];
    int           m_t;
    logic [7:0]   m_cur;
    logic         m_ovf;

    always #5 clk = ~clk;

    dbg_uart_tx_fifo #(
        .CLK_HZ  (CLK_HZ),
        .BIT_RATE(BIT_RATE),
        .DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .full    (full),
        .level   (level),
        .busy    (busy),
        .overflow(overflow),
        .uart_txd(uart_txd)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int b;
        if (m_t < 0) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    function automatic logic m_busy();
        return (m_t >= 0) || (m_q.size() != 0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_t   = -1;
        m_cur = 8'h00;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] d, input logic clr);
        bit was_full;
        bit do_pop;
        was_full = (m_q.size() == DEPTH);
        do_pop   = (m_q.size() != 0) && ((m_t < 0) || (m_t == FRAME - 1));
        if (do_pop) begin
            m_cur = m_q.pop_front();
            m_t   = 0;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == FRAME) m_t = -1;
        end
        if (we && !was_full) m_q.push_back(d);
        if (we && was_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        check_val("txd", uart_txd, exp_txd());
        check_val("level", level, m_q.size());
        check_val("full", full, (m_q.size() == DEPTH));
        check_val("busy", busy, m_busy());
        check_val("overflow", overflow, m_ovf);
    endtask

    // Inputs change just after a falling edge; outputs are compared on the next falling edge.
    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        wr_en   = we;
        wr_data = d;
        clr_ovf = clr;
        @(posedge clk);
        model_edge(we, d, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_until_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!m_busy()) break;
            step(1'b0, 8'h00, 1'b0);
        end
        repeat (3) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        model_reset();
        #12;
        check_val("rst_txd", uart_txd, 1'b1);
        check_val("rst_level", level, 5'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_full", full, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single 0xA5 frame
        step(1'b1, 8'hA5, 1'b0);
        repeat (FRAME + 10) step(1'b0, 8'h00, 1'b0);

        // Three back-to-back frames
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        idle_until_done(5 * FRAME);

        // Nine writes from idle: first pops after one cycle, so none are dropped
        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
        idle_until_done(12 * FRAME);

        // Ten writes behind an active frame: overflow, then clear paths
        step(1'b1, 8'($urandom), 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle_until_done(12 * FRAME);

        // Random traffic at several densities
        for (int p = 0; p < 4; p++) begin
            int dens;
            dens = (p == 0) ? 1 : (p == 1) ? 8 : (p == 2) ? 60 : 200;
            for (int i = 0; i < 800; i++) begin
                step(($urandom_range(0, dens) == 0), 8'($urandom), ($urandom_range(0, 60) == 0));
            end
        end
        idle_until_done(12 * FRAME);

        // Reset during data bit 4 with three bytes queued
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (m_t == 5 * CPB + 3) break;
            step(1'b0, 8'h00, 1'b0);
        end
        check_val("pre_rst_level", level, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_txd", uart_txd, 1'b1);
        check_val("async_rst_level", level, 5'd0);
        check_val("async_rst_busy", busy, 1'b0);
        check_val("async_rst_full", full, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h5C, 1'b0);
        idle_until_done(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
